// File: rtl/load_writeback_unit.sv
// Registered RISC-V write-back stage: result select, load lane alignment/extension,
// and a single pending load slot that back-pressures MEM/WB until data or timeout.
module load_writeback_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            RegWriteW,
  input  logic [1:0]      ResultSrcW,
  input  logic [2:0]      LoadTypeW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ALUResultW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            load_err
);
  localparam int OW = (XLEN == 64) ? 3 : 2;
  localparam bit IS64 = (XLEN == 64);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [4:0]    rd;
    logic          we;
    logic [2:0]    lt;
    logic [OW-1:0] off;
  } pend_t;

  function automatic logic [XLEN-1:0] align_ext(input logic [XLEN-1:0] raw,
                                                input logic [2:0] lt,
                                                input logic [OW-1:0] off);
    logic [XLEN-1:0] d;
    d = raw >> {off, 3'b000};
    case (lt)
      3'b000:  align_ext = XLEN'($signed(d[7:0]));
      3'b001:  align_ext = XLEN'($signed(d[15:0]));
      3'b010:  align_ext = XLEN'($signed(d[31:0]));
      3'b011:  align_ext = XLEN'(d[7:0]);
      3'b100:  align_ext = XLEN'(d[15:0]);
      3'b101:  align_ext = XLEN'(d[31:0]);
      default: align_ext = d;
    endcase
  endfunction

  // Misaligned or reserved encodings; lwu/ld only exist on the 64-bit datapath.
  function automatic logic load_bad(input logic [2:0] lt, input logic [OW-1:0] off);
    case (lt)
      3'b001, 3'b100: load_bad = off[0];
      3'b010:         load_bad = (off[1:0] != 2'b00);
      3'b101:         load_bad = !IS64 || (off[1:0] != 2'b00);
      3'b110:         load_bad = !IS64 || (off != '0);
      3'b111:         load_bad = 1'b1;
      default:        load_bad = 1'b0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  pend_t           pend_q, pend_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            load_err_q, load_err_d;
  logic [OW-1:0]   in_off;

  assign in_off = ALUResultW[OW-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    load_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (ResultSrcW)
            2'b00, 2'b10: begin
              rf_we_d    = RegWriteW && (RdW != 5'd0);
              rf_waddr_d = RdW;
              rf_wdata_d = ResultSrcW[1] ? PCPlus4W : ALUResultW;
            end
            2'b01: begin
              if (load_bad(LoadTypeW, in_off)) begin
                load_err_d = 1'b1;
              end else if (mem_rvalid) begin
                rf_we_d    = RegWriteW && (RdW != 5'd0);
                rf_waddr_d = RdW;
                rf_wdata_d = align_ext(mem_rdata, LoadTypeW, in_off);
              end else begin
                pend_d  = '{rd: RdW, we: RegWriteW, lt: LoadTypeW, off: in_off};
                cnt_d   = 8'd0;
                state_d = WAIT;
              end
            end
            default: ;
          endcase
        end
      end
      WAIT: begin
        // Data arriving on the final counted cycle still completes the load.
        if (mem_rvalid) begin
          rf_we_d    = pend_q.we && (pend_q.rd != 5'd0);
          rf_waddr_d = pend_q.rd;
          rf_wdata_d = align_ext(mem_rdata, pend_q.lt, pend_q.off);
          state_d    = IDLE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      pend_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      load_err_q <= load_err_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == WAIT);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_load_writeback_unit.sv
// Scoreboard bench for load_writeback_unit: stimulus pushes expected writes/errors,
// a negedge monitor pops and compares whenever the DUT pulses rf_we or load_err.
module tb_load_writeback_unit;
  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, RegWriteW;
  logic [1:0]      ResultSrcW;
  logic [2:0]      LoadTypeW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ALUResultW, PCPlus4W, mem_rdata;
  logic            mem_rvalid;
  logic            rf_we, busy, load_err;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  load_writeback_unit #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .LoadTypeW(LoadTypeW),
    .RdW(RdW), .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              err;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_w(input logic [4:0] a, input logic [XLEN-1:0] d);
    exp_t e;
    e.err = 1'b0; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic push_e();
    exp_t e;
    e.err = 1'b1; e.addr = '0; e.data = '0;
    q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic [2:0] lt,
                       input logic [4:0] rd, input logic [XLEN-1:0] alu, input logic rv,
                       input logic [XLEN-1:0] rdata);
    in_valid = v; RegWriteW = rw; ResultSrcW = rs; LoadTypeW = lt; RdW = rd;
    ALUResultW = alu; PCPlus4W = alu + 32'h100; mem_rvalid = rv; mem_rdata = rdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, '0, 1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (rf_we || load_err)) begin
      exp_t e;
      n_chk++;
      if (rf_we && load_err) begin
        n_fail++;
        $display("FAIL excl: rf_we and load_err both high at %0t", $time);
      end else if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected: we=%0b err=%0b addr=%0d data=0x%0h expected no output at %0t",
                 rf_we, load_err, rf_waddr, rf_wdata, $time);
      end else begin
        e = q.pop_front();
        if (e.err != load_err || (!e.err && (rf_waddr !== e.addr || rf_wdata !== e.data))) begin
          n_fail++;
          $display("FAIL scoreboard: got err=%0b addr=%0d data=0x%0h expected err=%0b addr=%0d data=0x%0h at %0t",
                   load_err, rf_waddr, rf_wdata, e.err, e.addr, e.data, $time);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    check("in_ready_in_reset", in_ready, 1);
    #20;
    check("rst_rf_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", load_err, 0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Back-to-back ALU results, no bubbles
    drive(1, 1, 2'b00, 3'b000, 5'd5, 32'h11, 0, '0); push_w(5, 32'h11); check("b2b_ready0", in_ready, 1); step();
    drive(1, 1, 2'b00, 3'b000, 5'd6, 32'h22, 0, '0); push_w(6, 32'h22); check("b2b_ready1", in_ready, 1); step();
    drive(1, 1, 2'b00, 3'b000, 5'd7, 32'h33, 0, '0); push_w(7, 32'h33); check("b2b_ready2", in_ready, 1); step();
    // PC+4 select (PCPlus4W = ALUResultW + 0x100)
    drive(1, 1, 2'b10, 3'b000, 5'd1, 32'h400, 0, '0); push_w(1, 32'h500); step();

    // lb / lbu at offset 3 with same-cycle rvalid
    drive(1, 1, 2'b01, 3'b000, 5'd8, 32'h1003, 1, 32'h80FF_1234); push_w(8, 32'hFFFF_FF80); step();
    drive(1, 1, 2'b01, 3'b011, 5'd9, 32'h1003, 1, 32'h80FF_1234); push_w(9, 32'h0000_0080); step();
    // lhu offset 2, lw offset 0
    drive(1, 1, 2'b01, 3'b100, 5'd2, 32'h1002, 1, 32'h8001_0000); push_w(2, 32'h0000_8001); step();
    drive(1, 1, 2'b01, 3'b010, 5'd3, 32'h1000, 1, 32'hCAFE_F00D); push_w(3, 32'hCAFE_F00D); step();
    idle(); step();

    // lh at offset 2, data three WAIT cycles late
    drive(1, 1, 2'b01, 3'b001, 5'd4, 32'h1002, 0, '0); push_w(4, 32'hFFFF_8001); step();
    idle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000; end
      check("lh_wait_ready", in_ready, 0);
      check("lh_wait_busy", busy, 1);
      step();
    end
    idle();
    check("lh_done_ready", in_ready, 1);
    check("lh_done_busy", busy, 0);
    check("lh_done_we", rf_we, 1);
    step();

    // Misaligned and reserved loads
    drive(1, 1, 2'b01, 3'b010, 5'd10, 32'h1002, 1, 32'h1234_5678); push_e(); step();
    check("mis_lw_ready", in_ready, 1);
    drive(1, 1, 2'b01, 3'b001, 5'd10, 32'h1001, 1, 32'h1234_5678); push_e(); step();
    drive(1, 1, 2'b01, 3'b101, 5'd10, 32'h1000, 1, 32'h1234_5678); push_e(); step();
    drive(1, 1, 2'b01, 3'b111, 5'd10, 32'h1000, 1, 32'h1234_5678); push_e(); step();
    // Reserved result source: silent
    drive(1, 1, 2'b11, 3'b000, 5'd10, 32'h77, 1, '0); step();
    idle(); step();

    // Timeout after TO WAIT cycles
    drive(1, 1, 2'b01, 3'b010, 5'd11, 32'h2000, 0, '0); push_e(); step();
    idle();
    for (int i = 0; i < TO; i++) begin
      check("to_wait_ready", in_ready, 0);
      step();
    end
    check("to_done_ready", in_ready, 1);
    check("to_done_busy", busy, 0);
    check("to_done_err", load_err, 1);
    step();

    // rvalid on the timeout cycle wins
    drive(1, 1, 2'b01, 3'b010, 5'd12, 32'h2004, 0, '0); push_w(12, 32'hDEAD_BEEF); step();
    idle();
    for (int i = 0; i < TO; i++) begin
      if (i == TO - 1) begin mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      step();
    end
    idle();
    check("to_race_we", rf_we, 1);
    check("to_race_err", load_err, 0);
    step();

    // x0 and RegWriteW=0: no write, but address/data still update
    drive(1, 1, 2'b00, 3'b000, 5'd0, 32'h55, 0, '0); step();
    check("x0_we", rf_we, 0);
    check("x0_waddr", rf_waddr, 0);
    check("x0_wdata", rf_wdata, 32'h55);
    drive(1, 1, 2'b01, 3'b000, 5'd0, 32'h1000, 1, 32'h0000_00AA); step();
    check("x0_load_wdata", rf_wdata, 32'hFFFF_FFAA);
    drive(1, 0, 2'b00, 3'b000, 5'd13, 32'h66, 0, '0); step();
    check("nowe_waddr", rf_waddr, 13);
    idle(); step();

    // Reset mid-WAIT drops the pending load
    drive(1, 1, 2'b01, 3'b010, 5'd14, 32'h3000, 0, '0); step();
    idle(); step();
    check("mid_busy", busy, 1);
    rst_n = 1'b0; #1;
    check("mr_ready", in_ready, 1);
    check("mr_busy", busy, 0);
    check("mr_waddr", rf_waddr, 0);
    check("mr_wdata", rf_wdata, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; step();
    idle(); step();
    check("post_rst_we", rf_we, 0);
    check("post_rst_err", load_err, 0);
    step(); step();

    check("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
